mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between instruction fetch and data access (lw/sw issued by the control unit via d_ren/d_wen).
- Registered grant FSM. Data side has priority, with a bounded-burst anti-starvation rule for fetch.
- Sits between the datapath/cache front ends and the RAM model. Uses word_t and ramstate_t from cpu_types_pkg.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/diaosi_types_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/arb_burst_ctr.sv | 26 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Arbiter-local types: grant state encoding and burst limit defaults.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int MAX_DBURST_DEFAULT = 4;
  // Wide enough for any burst limit in 1..7.
  localparam int BURST_W = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's front-end and RAM-side signals, with arbiter and bench views.
interface mem_arbiter_if
  import cpu_types_pkg::*;
(
  input logic CLK,
  input logic nRST
);

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
`ifdef MEM_ARB_STATS_EN
  word_t     icount;
  word_t     dcount;
  word_t     stallcnt;
`endif

  modport arb (
    input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
`ifdef MEM_ARB_STATS_EN
    , output icount, dcount, stallcnt
`endif
  );

  modport tb (
    input  CLK, nRST, iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate
`ifdef MEM_ARB_STATS_EN
    , input icount, dcount, stallcnt
`endif
  );

endinterface

// File: rtl/arb_burst_ctr.sv
// Saturating up-counter with synchronous clear; tracks consecutive data grants.
module arb_burst_ctr #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Clear wins over increment so a fetch completion always resets the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter: data has priority, fetch gets a turn after MAX_DBURST data grants.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int MAX_DBURST = MAX_DBURST_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output word_t     icount,
  output word_t     dcount,
  output word_t     stallcnt
`endif
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DBURST);

  arb_state_t         state;
  arb_state_t         next_state;
  logic               d_req;
  logic               d_write;
  logic               i_done;
  logic               d_done;
  logic               burst_full;
  logic [BURST_W-1:0] burst_cnt;

  // A simultaneous read+write request is treated as a write.
  assign d_req      = dREN | dWEN;
  assign d_write    = dWEN;
  assign i_done     = (state == IGNT) && iREN  && (ramstate == ACCESS);
  assign d_done     = (state == DGNT) && d_req && (ramstate == ACCESS);
  assign burst_full = (burst_cnt == BURST_MAX);

  arb_burst_ctr #(
    .MAX (MAX_DBURST),
    .W   (BURST_W)
  ) u_burst (
    .clk   (CLK),
    .rst_n (nRST),
    .clr   (!iREN || i_done),
    .inc   (d_done && iREN),
    .count (burst_cnt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Every granted access returns to IDLE, so each request is re-arbitrated.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req && !(burst_full && iREN)) next_state = DGNT;
        else if (iREN)                      next_state = IGNT;
      end
      IGNT: begin
        if (!iREN || (ramstate == ACCESS) || (ramstate == ERROR)) next_state = IDLE;
      end
      DGNT: begin
        if (!d_req || (ramstate == ACCESS) || (ramstate == ERROR)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    case (state)
      IGNT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
        end
        if (i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGNT: begin
        if (d_req) begin
          ramaddr = daddr;
          if (d_write) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
        end
        if (d_done) begin
          dwait = 1'b0;
          dload = d_write ? '0 : ramload;
        end
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount   <= '0;
      dcount   <= '0;
      stallcnt <= '0;
    end else begin
      if (i_done)         icount   <= icount + 32'd1;
      if (d_done)         dcount   <= dcount + 32'd1;
      if (iREN && iwait)  stallcnt <= stallcnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; statistics checks follow MEM_ARB_STATS_EN.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if u_if (.CLK(clk), .nRST(n_rst));

  mem_arbiter #(.MAX_DBURST(4)) dut (
    .CLK      (clk),
    .nRST     (n_rst),
    .iREN     (u_if.iREN),
    .iaddr    (u_if.iaddr),
    .iwait    (u_if.iwait),
    .iload    (u_if.iload),
    .dREN     (u_if.dREN),
    .dWEN     (u_if.dWEN),
    .daddr    (u_if.daddr),
    .dstore   (u_if.dstore),
    .dwait    (u_if.dwait),
    .dload    (u_if.dload),
    .ramREN   (u_if.ramREN),
    .ramWEN   (u_if.ramWEN),
    .ramaddr  (u_if.ramaddr),
    .ramstore (u_if.ramstore),
    .ramload  (u_if.ramload),
    .ramstate (u_if.ramstate)
`ifdef MEM_ARB_STATS_EN
    ,
    .icount   (u_if.icount),
    .dcount   (u_if.dcount),
    .stallcnt (u_if.stallcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic i_ren, input word_t i_addr,
                                input logic d_ren, input logic d_wen,
                                input word_t d_addr, input word_t d_store,
                                input ramstate_t rs, input word_t r_load);
    u_if.iREN     = i_ren;
    u_if.iaddr    = i_addr;
    u_if.dREN     = d_ren;
    u_if.dWEN     = d_wen;
    u_if.daddr    = d_addr;
    u_if.dstore   = d_store;
    u_if.ramstate = rs;
    u_if.ramload  = r_load;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic d_exp;
    logic i_exp;

    // Reset values
    n_rst = 1'b0;
    apply_stimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    check_output("rst_ramREN",   u_if.ramREN,   0);
    check_output("rst_ramWEN",   u_if.ramWEN,   0);
    check_output("rst_ramaddr",  u_if.ramaddr,  0);
    check_output("rst_ramstore", u_if.ramstore, 0);
    check_output("rst_iwait",    u_if.iwait,    1);
    check_output("rst_dwait",    u_if.dwait,    1);
    check_output("rst_iload",    u_if.iload,    0);
    check_output("rst_dload",    u_if.dload,    0);
    tick();
    n_rst = 1'b1;
    tick();

    $display("[TB] fetch only");
    apply_stimulus(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0, BUSY, 32'h2001_0005);
    check_output("f_idle_ramREN", u_if.ramREN, 0);
    check_output("f_idle_iwait",  u_if.iwait,  1);
    tick();
    check_output("f_b1_ramREN",  u_if.ramREN,  1);
    check_output("f_b1_ramaddr", u_if.ramaddr, 32'h0000_0040);
    check_output("f_b1_iwait",   u_if.iwait,   1);
    check_output("f_b1_iload",   u_if.iload,   0);
    tick();
    check_output("f_b2_ramREN", u_if.ramREN, 1);
    check_output("f_b2_iwait",  u_if.iwait,  1);
    apply_stimulus(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0, ACCESS, 32'h2001_0005);
    check_output("f_acc_iwait", u_if.iwait, 0);
    check_output("f_acc_iload", u_if.iload, 32'h2001_0005);
    check_output("f_acc_dwait", u_if.dwait, 1);
    tick();
    apply_stimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h2001_0005);
    check_output("f_done_ramREN", u_if.ramREN, 0);
    check_output("f_done_iwait",  u_if.iwait,  1);
    check_output("f_done_iload",  u_if.iload,  0);
    tick();

    $display("[TB] simultaneous requests");
    apply_stimulus(1, 32'h0000_0040, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, BUSY, 32'h0000_1234);
    check_output("s_idle_ramWEN", u_if.ramWEN, 0);
    tick();
    check_output("s_d_ramWEN",   u_if.ramWEN,   1);
    check_output("s_d_ramREN",   u_if.ramREN,   0);
    check_output("s_d_ramaddr",  u_if.ramaddr,  32'h0000_0100);
    check_output("s_d_ramstore", u_if.ramstore, 32'hDEAD_BEEF);
    check_output("s_d_dwait",    u_if.dwait,    1);
    check_output("s_d_iwait",    u_if.iwait,    1);
    apply_stimulus(1, 32'h0000_0040, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, ACCESS, 32'h0000_1234);
    check_output("s_d_acc_dwait", u_if.dwait, 0);
    check_output("s_d_acc_dload", u_if.dload, 0);
    check_output("s_d_acc_iwait", u_if.iwait, 1);
    tick();
    apply_stimulus(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0, BUSY, 32'h0A0A_0A0A);
    check_output("s_idle2_ramREN", u_if.ramREN, 0);
    tick();
    check_output("s_i_ramREN",  u_if.ramREN,  1);
    check_output("s_i_ramaddr", u_if.ramaddr, 32'h0000_0040);
    apply_stimulus(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0A0A_0A0A);
    check_output("s_i_acc_iwait", u_if.iwait, 0);
    check_output("s_i_acc_iload", u_if.iload, 32'h0A0A_0A0A);
    check_output("s_i_acc_dwait", u_if.dwait, 1);
    tick();
    apply_stimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    tick();

    $display("[TB] starvation bound");
    apply_stimulus(1, 32'h0000_0080, 1, 0, 32'h0000_0200, 32'h0, ACCESS, 32'h0000_5555);
    for (int c = 0; c < 20; c++) begin
      d_exp = ((c % 10) % 2 == 1) && ((c % 10) != 9);
      i_exp = ((c % 10) == 9);
      check_output($sformatf("st_dwait_c%0d", c), u_if.dwait, !d_exp);
      check_output($sformatf("st_iwait_c%0d", c), u_if.iwait, !i_exp);
      check_output($sformatf("st_dload_c%0d", c), u_if.dload, d_exp ? 32'h0000_5555 : 32'h0);
      check_output($sformatf("st_iload_c%0d", c), u_if.iload, i_exp ? 32'h0000_5555 : 32'h0);
      tick();
      #1;
    end
    apply_stimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    tick();

    $display("[TB] error retry");
    apply_stimulus(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0, ERROR, 32'h0000_0077);
    check_output("e_idle_ramREN", u_if.ramREN, 0);
    tick();
    check_output("e_g1_ramREN",  u_if.ramREN,  1);
    check_output("e_g1_ramaddr", u_if.ramaddr, 32'h0000_0044);
    check_output("e_g1_iwait",   u_if.iwait,   1);
    tick();
    check_output("e_idle2_ramREN", u_if.ramREN, 0);
    check_output("e_idle2_iwait",  u_if.iwait,  1);
    tick();
    check_output("e_g2_ramREN", u_if.ramREN, 1);
    apply_stimulus(1, 32'h0000_0044, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0000_0077);
    check_output("e_g2_iwait", u_if.iwait, 0);
    check_output("e_g2_iload", u_if.iload, 32'h0000_0077);
    tick();

    $display("[TB] data abort");
    apply_stimulus(0, 32'h0, 1, 0, 32'h0000_0300, 32'h0, BUSY, 32'h0000_0099);
    tick();
    check_output("a_g_ramREN",  u_if.ramREN,  1);
    check_output("a_g_ramaddr", u_if.ramaddr, 32'h0000_0300);
    check_output("a_g_dwait",   u_if.dwait,   1);
    apply_stimulus(0, 32'h0, 0, 0, 32'h0000_0300, 32'h0, BUSY, 32'h0000_0099);
    check_output("a_drop_dwait", u_if.dwait, 1);
    tick();
    check_output("a_idle_dwait",  u_if.dwait,  1);
    check_output("a_idle_ramREN", u_if.ramREN, 0);
    tick();
    check_output("a_idle2_dwait", u_if.dwait, 1);

    $display("[TB] reset during write");
    apply_stimulus(0, 32'h0, 0, 1, 32'h0000_0400, 32'h0000_CAFE, BUSY, 32'h0);
    tick();
    check_output("r_pre_ramWEN", u_if.ramWEN, 1);
    n_rst = 1'b0;
    #1;
    check_output("r_async_ramWEN",   u_if.ramWEN,   0);
    check_output("r_async_ramaddr",  u_if.ramaddr,  0);
    check_output("r_async_ramstore", u_if.ramstore, 0);
    check_output("r_async_iwait",    u_if.iwait,    1);
    check_output("r_async_dwait",    u_if.dwait,    1);
    apply_stimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    tick();
    n_rst = 1'b1;
    tick();
    check_output("r_post_ramREN", u_if.ramREN, 0);
    check_output("r_post_ramWEN", u_if.ramWEN, 0);

    $display("[TB] statistics workload");
    apply_stimulus(1, 32'h0000_0050, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0000_0099);
    for (int k = 0; k < 6; k++) begin
      check_output($sformatf("x_iwait_k%0d", k), u_if.iwait, (k % 2 == 1) ? 32'h0 : 32'h1);
      tick();
    end
    apply_stimulus(0, 32'h0, 1, 0, 32'h0000_0060, 32'h0, ACCESS, 32'h0000_0099);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("x_dwait_k%0d", k), u_if.dwait, (k % 2 == 1) ? 32'h0 : 32'h1);
      tick();
    end
    apply_stimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
`ifdef MEM_ARB_STATS_EN
    check_output("x_icount",   u_if.icount,   32'd3);
    check_output("x_dcount",   u_if.dcount,   32'd2);
    check_output("x_stallcnt", u_if.stallcnt, 32'd3);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
